// File: rtl/stack_mover_if.sv
// Shared dual-stack push/pop bus: the initiator drives select/strobes/data,
// the stacks return OR-ed read data and their registered flags.
interface stack_bus_if #(
    parameter int WIDTH = 8
);
    logic             stack_select;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] data_to_stack;
    logic [WIDTH-1:0] data_from_stack;
    logic             empty0;
    logic             full0;
    logic             empty1;
    logic             full1;

    modport master (
        output stack_select, push, pop, data_to_stack,
        input  data_from_stack, empty0, full0, empty1, full1
    );

    modport slave (
        input  stack_select, push, pop, data_to_stack,
        output data_from_stack, empty0, full0, empty1, full1
    );
endinterface

// File: rtl/stack_mover.sv
// Moves words one at a time from the top of one stack to the top of the other,
// stopping on count, source empty, destination full or abort.
module stack_mover #(
    parameter int WIDTH       = 8,
    parameter int CNT_BITS    = 8,
    parameter bit IDLE_SELECT = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                dir,
    input  logic [CNT_BITS-1:0] count,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic [1:0]          status,
    output logic [CNT_BITS-1:0] moved,
    stack_bus_if.master         bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PREP  = 3'd1,
        READ  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [1:0] ST_COUNT = 2'b00;
    localparam logic [1:0] ST_EMPTY = 2'b01;
    localparam logic [1:0] ST_FULL  = 2'b10;
    localparam logic [1:0] ST_ABORT = 2'b11;

    state_t              state, state_nx;
    logic                dir_q;
    logic [CNT_BITS-1:0] count_q;
    logic [WIDTH-1:0]    word;
    logic                abort_q;
    logic [1:0]          status_nx;
    logic                src_empty, dst_full;
    logic                accept;
    logic                dir_nx;

    assign accept    = (state == IDLE) && start;
    assign dir_nx    = accept ? dir : dir_q;
    assign src_empty = dir_q ? bus.empty1 : bus.empty0;
    assign dst_full  = dir_q ? bus.full0  : bus.full1;

    // Registered word doubles as the push data bus
    assign bus.data_to_stack = word;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        status_nx = status;
        case (state)
            IDLE:  if (start) state_nx = PREP;
            PREP: begin
                if (abort || abort_q) begin
                    state_nx  = DONE;
                    status_nx = ST_ABORT;
                end else if ((count_q != '0) && (moved == count_q)) begin
                    state_nx  = DONE;
                    status_nx = ST_COUNT;
                end else if (src_empty) begin
                    state_nx  = DONE;
                    status_nx = ST_EMPTY;
                end else if (dst_full) begin
                    state_nx  = DONE;
                    status_nx = ST_FULL;
                end else begin
                    state_nx  = READ;
                end
            end
            READ:    state_nx = WRITE;
            WRITE:   state_nx = PREP;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Bus and status outputs are registered from the next-state decode so they
    // line up with the state they describe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy             <= 1'b0;
            done             <= 1'b0;
            status           <= ST_COUNT;
            moved            <= '0;
            bus.stack_select <= IDLE_SELECT;
            bus.push         <= 1'b0;
            bus.pop          <= 1'b0;
            dir_q            <= 1'b0;
            count_q          <= '0;
            word             <= '0;
            abort_q          <= 1'b0;
        end else begin
            busy     <= (state_nx == PREP) || (state_nx == READ) || (state_nx == WRITE);
            done     <= (state_nx == DONE);
            bus.pop  <= (state_nx == READ);
            bus.push <= (state_nx == WRITE);
            status   <= status_nx;

            case (state_nx)
                PREP, READ: bus.stack_select <= dir_nx;
                WRITE:      bus.stack_select <= ~dir_nx;
                default:    bus.stack_select <= IDLE_SELECT;
            endcase

            if (accept) begin
                dir_q   <= dir;
                count_q <= count;
                moved   <= '0;
            end

            if (state == READ)  word  <= bus.data_from_stack;
            if (state == WRITE) moved <= moved + 1'b1;

            // Abort raised while a word is in flight is held for the next PREP
            if (state == PREP)
                abort_q <= 1'b0;
            else if (((state == READ) || (state == WRITE)) && abort)
                abort_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_stack_mover.sv
// Directed bench: two behavioural 16-deep stacks on the shared bus around stack_mover.
module tb_stack_mover;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       dir = 1'b0;
    logic [7:0] count = '0;
    logic       abort = 1'b0;
    logic       busy, done;
    logic [1:0] status;
    logic [7:0] moved;

    logic       pre_push = 1'b0;
    logic       pre_addr = 1'b0;
    logic [7:0] pre_data = '0;

    int n_pass = 0;
    int n_total = 0;

    stack_bus_if #(.WIDTH(8)) bus ();

    stack_mover #(.WIDTH(8), .CNT_BITS(8), .IDLE_SELECT(1'b0)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .dir    (dir),
        .count  (count),
        .abort  (abort),
        .busy   (busy),
        .done   (done),
        .status (status),
        .moved  (moved),
        .bus    (bus.master)
    );

    always #5 clk = ~clk;

    // Stack model: registered data_out of the selected stack, 0 when unselected
    logic [7:0] mem [2][16];
    int         sp [2];
    logic [7:0] dout;

    always @(posedge clk) begin
        if (!rst_n) begin
            sp[0] <= 0;
            sp[1] <= 0;
            dout  <= '0;
        end else begin
            if (sp[bus.stack_select] != 0) dout <= mem[bus.stack_select][sp[bus.stack_select]-1];
            else                           dout <= '0;
            for (int a = 0; a < 2; a++) begin
                if (pre_push && (int'(pre_addr) == a) && sp[a] < 16) begin
                    mem[a][sp[a]] <= pre_data;
                    sp[a]         <= sp[a] + 1;
                end else if (bus.push && (int'(bus.stack_select) == a) && sp[a] < 16) begin
                    mem[a][sp[a]] <= bus.data_to_stack;
                    sp[a]         <= sp[a] + 1;
                end else if (bus.pop && (int'(bus.stack_select) == a) && sp[a] > 0) begin
                    sp[a] <= sp[a] - 1;
                end
            end
        end
    end

    assign bus.data_from_stack = dout;
    assign bus.empty0 = (sp[0] == 0);
    assign bus.full0  = (sp[0] == 16);
    assign bus.empty1 = (sp[1] == 0);
    assign bus.full1  = (sp[1] == 16);

    // Bus monitor
    logic [7:0] ldat [$];
    logic       laddr [$];
    int         npop = 0;
    int         overlap = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.push) begin
                ldat.push_back(bus.data_to_stack);
                laddr.push_back(bus.stack_select);
            end
            if (bus.pop) npop++;
            if (bus.push && bus.pop) overlap++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic preload(input logic a, input logic [7:0] d);
        pre_push = 1'b1;
        pre_addr = a;
        pre_data = d;
        tick();
        pre_push = 1'b0;
    endtask

    task automatic launch(input logic d, input logic [7:0] c);
        dir   = d;
        count = c;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Cycle index after the start-sampling edge at which done is seen
    task automatic wait_done(input int c0, output int cyc);
        cyc = c0;
        while (!done && cyc < 200) begin
            tick();
            cyc++;
        end
    endtask

    int cyc, n0, p0;

    initial begin
        do_reset();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_status", status, 0);
        chk("rst_moved", moved, 0);
        chk("rst_push_pop", {bus.push, bus.pop}, 0);
        chk("rst_data", bus.data_to_stack, 0);
        chk("rst_select", bus.stack_select, 0);

        // 3 words, unlimited: reversed into stack1, stops on source empty
        preload(1'b0, 8'h11);
        preload(1'b0, 8'h22);
        preload(1'b0, 8'h33);
        n0 = ldat.size();
        launch(1'b0, 8'd0);
        chk("t1_busy", busy, 1);
        wait_done(1, cyc);
        chk("t1_latency", cyc, 11);
        chk("t1_status", status, 2'b01);
        chk("t1_moved", moved, 3);
        chk("t1_empty0", bus.empty0, 1);
        chk("t1_npush", ldat.size() - n0, 3);
        if (ldat.size() - n0 == 3) begin
            chk("t1_w0", ldat[n0], 8'h33);
            chk("t1_w1", ldat[n0+1], 8'h22);
            chk("t1_w2", ldat[n0+2], 8'h11);
            chk("t1_addr", {laddr[n0], laddr[n0+1], laddr[n0+2]}, 3'b111);
        end
        tick();
        chk("t1_done_pulse", done, 0);

        // Count-limited move of 2 out of 5
        do_reset();
        for (int i = 1; i <= 5; i++) preload(1'b0, 8'(i));
        n0 = ldat.size();
        p0 = npop;
        launch(1'b0, 8'd2);
        wait_done(1, cyc);
        chk("t2_latency", cyc, 8);
        chk("t2_status", status, 2'b00);
        chk("t2_moved", moved, 2);
        chk("t2_npush", ldat.size() - n0, 2);
        chk("t2_npop", npop - p0, 2);
        chk("t2_sp0", sp[0], 3);

        // Destination fills after 2 words
        do_reset();
        for (int i = 0; i < 14; i++) preload(1'b1, 8'hA0 + 8'(i));
        for (int i = 0; i < 4; i++) preload(1'b0, 8'hB0 + 8'(i));
        launch(1'b0, 8'd0);
        wait_done(1, cyc);
        chk("t3_latency", cyc, 8);
        chk("t3_status", status, 2'b10);
        chk("t3_moved", moved, 2);
        chk("t3_full1", bus.full1, 1);
        chk("t3_sp0", sp[0], 2);

        // Abort during the second READ: in-flight word is still delivered
        do_reset();
        for (int i = 1; i <= 4; i++) preload(1'b1, 8'hC0 + 8'(i));
        n0 = ldat.size();
        launch(1'b1, 8'd0);
        tick();
        tick();
        tick();
        tick();
        chk("t4_pop_read2", bus.pop, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_done(6, cyc);
        chk("t4_latency", cyc, 8);
        chk("t4_status", status, 2'b11);
        chk("t4_moved", moved, 2);
        chk("t4_sp1", sp[1], 2);
        chk("t4_sp0", sp[0], 2);
        if (ldat.size() - n0 == 2) begin
            chk("t4_w0", ldat[n0], 8'hC4);
            chk("t4_w1", ldat[n0+1], 8'hC3);
            chk("t4_addr", {laddr[n0], laddr[n0+1]}, 2'b00);
        end else begin
            chk("t4_npush", ldat.size() - n0, 2);
        end

        // Empty source: zero-word stop
        do_reset();
        n0 = ldat.size();
        p0 = npop;
        launch(1'b0, 8'd0);
        wait_done(1, cyc);
        chk("t5_latency", cyc, 2);
        chk("t5_status", status, 2'b01);
        chk("t5_moved", moved, 0);
        chk("t5_no_strobes", (ldat.size() - n0) + (npop - p0), 0);

        // Reset in the middle of a WRITE, then a normal transfer
        for (int i = 1; i <= 4; i++) preload(1'b0, 8'hD0 + 8'(i));
        launch(1'b0, 8'd0);
        tick();
        tick();
        chk("t6_in_write", bus.push, 1);
        rst_n = 1'b0;
        tick();
        chk("t6_busy", busy, 0);
        chk("t6_push_pop", {bus.push, bus.pop}, 0);
        chk("t6_moved", moved, 0);
        chk("t6_status", status, 2'b00);
        rst_n = 1'b1;
        preload(1'b0, 8'hE1);
        preload(1'b0, 8'hE2);
        launch(1'b0, 8'd0);
        wait_done(1, cyc);
        chk("t6_latency", cyc, 8);
        chk("t6_moved_after", moved, 2);
        chk("t6_status_after", status, 2'b01);

        chk("no_push_pop_overlap", overlap, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
